// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 max-pooling over pairs of requantised int8 rows.
// Even rows fill the row buffer; odd rows pool against it, one channel per clock.
module relu_maxpool2x2 #(
  parameter int H          = 24,
  parameter int K          = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [0:H*K*DATA_WIDTH-1]         data_i,
  input  logic                              done_i,
  input  logic                              clear_i,
  output logic [0:(H/2)*K*DATA_WIDTH-1]     data_o,
  output logic                              done_o,
  output logic                              busy_o,
  output logic                              overrun_o
);

  localparam int DW    = DATA_WIDTH;
  localparam int HO    = H / 2;
  localparam int IN_W  = H * K * DW;
  localparam int OUT_W = HO * K * DW;
  localparam int CH_W  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, PROC, FIN} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              parity_q, parity_d;
  logic [0:IN_W-1]   in_q, in_d;
  logic [0:IN_W-1]   buf_q, buf_d;
  logic [0:OUT_W-1]  data_q, data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

  // Post-ReLU values are non-negative, so an unsigned compare is exact.
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    parity_d  = parity_q;
    in_d      = in_q;
    buf_d     = buf_q;
    data_d    = data_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    if (clear_i) begin
      state_d   = IDLE;
      ch_d      = '0;
      parity_d  = 1'b0;
      busy_d    = 1'b0;
      overrun_d = 1'b0;
      if (done_i) begin
        in_d    = data_i;
        state_d = PROC;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (done_i) begin
            in_d    = data_i;
            ch_d    = '0;
            state_d = PROC;
            busy_d  = 1'b1;
          end
        end
        PROC: begin
          if (done_i) overrun_d = 1'b1;
          if (!parity_q) begin
            for (int n = 0; n < H; n++) begin
              buf_d[(int'(ch_q)*H + n)*DW +: DW] = relu(in_q[(int'(ch_q)*H + n)*DW +: DW]);
            end
          end else begin
            for (int j = 0; j < HO; j++) begin
              data_d[(int'(ch_q)*HO + j)*DW +: DW] =
                max2(max2(buf_q[(int'(ch_q)*H + 2*j)*DW +: DW],
                          buf_q[(int'(ch_q)*H + 2*j + 1)*DW +: DW]),
                     max2(relu(in_q[(int'(ch_q)*H + 2*j)*DW +: DW]),
                          relu(in_q[(int'(ch_q)*H + 2*j + 1)*DW +: DW])));
            end
          end
          ch_d = ch_q + CH_W'(1);
          if (ch_q == CH_W'(K-1)) state_d = FIN;
        end
        FIN: begin
          if (done_i) overrun_d = 1'b1;
          parity_d = ~parity_q;
          done_d   = parity_q;
          busy_d   = 1'b0;
          ch_d     = '0;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      parity_q  <= 1'b0;
      in_q      <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      parity_q  <= parity_d;
      in_q      <= in_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule
